pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Consumer side of the branch-condition path. Takes the taken/not-taken decision from the flag register unit, together with the instruction in EX, and owns the fetch PC.
- Computes branch, JAL and JR targets and redirects the PC.
- Squashes the wrong-path instructions already fetched by asserting flush for a fixed number of pipeline advances.
- Freezes fetch on HLT. Sits between the flag register unit / EX stage and the instruction-memory address port.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, pipeline advances squashed after a redirect; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ex_instr  input  16  instruction currently in EX; [15:12] opcode.
- ex_valid  input  1  ex_instr is a live (non-squashed) instruction.
- ex_pc_inc  input  16  PC+1 of the EX instruction.
- br_taken  input  1  condition result from the flag register unit; meaningful only for opcode B.
- rs_data  input  16  register value for JR target.
- stall  input  1  pipeline hold from hazard unit.
- pc  output  16  current fetch address (registered).
- flush  output  1  squash IF/ID contents this cycle (registered state, not combinational).
- halted  output  1  processor halted.

Behaviour:
- Reset (rst_n=0 at clk edge, mid-operation included): pc=RESET_PC, state=RUN, flush counter=0, flush=0, halted=0. Reset overrides every other input.
- Opcodes come from the shared opcode header: B, JAL, JR, HLT.
- Target computation, 16-bit mod 2^16 wrap, no overflow detection:
  - B: ex_pc_inc + sext(ex_instr[7:0]).
  - JAL: ex_pc_inc + sext(ex_instr[11:0]).
  - JR: rs_data.
- Redirect condition, evaluated in RUN only: ex_valid and (opcode B with br_taken=1, or JAL, or JR). A B instruction with br_taken=0 is not a redirect.
- States:
  - RUN:
    - Redirect: pc<=target next edge, regardless of stall; load counter=FLUSH_CYCLES; go FLUSH.
    - Else ex_valid and opcode HLT and not stall: pc holds; go HALT.
    - Else if stall: pc holds.
    - Else: pc<=pc+1, wrapping 16'hFFFF to 16'h0000.
  - FLUSH:
    - flush=1.
    - Redirect and HLT decoding are suppressed, because the EX instruction is wrong-path.
    - Non-stall cycle: pc<=pc+1 and counter decrements. Stall cycle: pc and counter hold.
    - Counter reaching 0: go RUN with flush=0 in that same cycle.
    - flush is therefore high for exactly FLUSH_CYCLES non-stalled cycles, beginning the cycle after the redirect edge.
  - HALT:
    - halted=1, pc frozen, flush=0.
    - All inputs ignored; only reset exits.
- Redirect and HLT are mutually exclusive by opcode. ex_valid=0 suppresses both.
- Latency: the target appears on pc one clock after the redirecting instruction is sampled in EX. halted rises one clock after HLT is sampled.
- No combinational path from any input to any output.

Decomposition:
- The shared opcode header supplies B/JAL/JR/HLT encodings.
- A small shared package or header adds the state encodings (RUN, FLUSH, HALT) and the offset-field bit positions.
- One natural sub-module: pc_target_calc. It is purely combinational, performs sign extension and the 16-bit add, and selects among the B, JAL and JR targets.
- FSM, counter and PC register remain in the top module.

Test Plan:
- Reset then 4 cycles with no stall and no redirects -> pc 0000,0001,0002,0003,0004; flush=0, halted=0.
- ex_valid=1, B with offset 8'hFC, ex_pc_inc=0010, br_taken=1 -> next pc=000C; flush=1 for exactly 2 cycles; pc 000D,000E; then flush=0. Same with br_taken=0 -> plain increment, flush never asserted.
- JAL offset 12'h7FF, ex_pc_inc=F900 -> pc=00FF (wrap). JR with rs_data=1234 asserted together with stall=1 -> pc=1234 and flush begins; a stall during FLUSH extends flush by one cycle per stalled cycle.
- In FLUSH, present a valid taken B and a HLT in EX -> both ignored; pc keeps incrementing; halted stays 0.
- HLT valid with stall=0 -> halted=1 next cycle; pc frozen for 10 cycles despite redirect stimulus. Then rst_n=0 -> pc=RESET_PC, halted=0 on that edge.
- Assert rst_n=0 during the second flush cycle -> flush=0, state RUN, pc=RESET_PC at that edge. pc at FFFF with no redirect -> next pc 0000.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: opcode encodings,
// controller states and the offset-field layout of control-flow instructions.
package pc_redirect_ctrl_pkg;

    localparam logic [3:0] OP_B   = 4'hA;
    localparam logic [3:0] OP_JAL = 4'hB;
    localparam logic [3:0] OP_JR  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 12;
    localparam int BR_OFF_MSB  = 7;
    localparam int JAL_OFF_MSB = 11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Sign-extend either the 8-bit branch offset or the 12-bit jump offset.
    function automatic logic [15:0] sext_off(input logic [11:0] field, input logic wide);
        logic [15:0] res;
        if (wide) begin
            res = {{4{field[JAL_OFF_MSB]}}, field};
        end else begin
            res = {{8{field[BR_OFF_MSB]}}, field[BR_OFF_MSB:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// EX-stage / fetch-side bundle seen by the PC redirect controller.
interface pc_redirect_ctrl_if;

    logic [15:0] ex_instr;
    logic        ex_valid;
    logic [15:0] ex_pc_inc;
    logic        br_taken;
    logic [15:0] rs_data;
    logic        stall;
    logic [15:0] pc;
    logic        flush;
    logic        halted;

    modport master (
        output ex_instr, ex_valid, ex_pc_inc, br_taken, rs_data, stall,
        input  pc, flush, halted
    );

    modport slave (
        input  ex_instr, ex_valid, ex_pc_inc, br_taken, rs_data, stall,
        output pc, flush, halted
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect-target selection for B, JAL and JR.
module pc_target_calc
    import pc_redirect_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [11:0] off_field,
    input  logic [15:0] ex_pc_inc,
    input  logic [15:0] rs_data,
    output logic [15:0] target
);

    logic [15:0] br_tgt_s;
    logic [15:0] jal_tgt_s;

    assign br_tgt_s  = ex_pc_inc + sext_off(off_field, 1'b0);
    assign jal_tgt_s = ex_pc_inc + sext_off(off_field, 1'b1);

    // Pick the target for the opcode; non-redirect opcodes fall through to PC+1.
    always_comb begin
        target = ex_pc_inc;
        case (op)
            OP_B:    target = br_tgt_s;
            OP_JAL:  target = jal_tgt_s;
            OP_JR:   target = rs_data;
            default: target = ex_pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Owns the fetch PC: redirects on taken branches/jumps, squashes the
// wrong-path fetches for FLUSH_CYCLES advances, and freezes on HLT.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned FLUSH_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    pc_redirect_ctrl_if.slave bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e      state_r;
    logic [15:0] pc_r;
    logic [2:0]  cnt_r;
    logic        flush_r;
    logic        halted_r;

    logic [3:0]  op_s;
    logic [15:0] target_s;
    logic        redirect_s;
    logic        hlt_s;

    assign op_s = bus.ex_instr[OP_MSB:OP_LSB];

    pc_target_calc u_target (
        .op        (op_s),
        .off_field (bus.ex_instr[JAL_OFF_MSB:0]),
        .ex_pc_inc (bus.ex_pc_inc),
        .rs_data   (bus.rs_data),
        .target    (target_s)
    );

    // Decode the EX instruction into redirect / halt requests.
    always_comb begin
        redirect_s = 1'b0;
        hlt_s      = 1'b0;
        if (bus.ex_valid) begin
            redirect_s = ((op_s == OP_B) && bus.br_taken) || (op_s == OP_JAL) || (op_s == OP_JR);
            hlt_s      = (op_s == OP_HLT);
        end else begin
            redirect_s = 1'b0;
            hlt_s      = 1'b0;
        end
    end

    // Controller FSM with PC register, flush counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            cnt_r    <= 3'd0;
            flush_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_s) begin
                        pc_r    <= target_s;
                        cnt_r   <= FLUSH_LOAD;
                        flush_r <= 1'b1;
                        state_r <= ST_FLUSH;
                    end else if (hlt_s && !bus.stall) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else if (!bus.stall) begin
                        pc_r <= pc_r + 16'd1;
                    end
                end
                // The EX instruction here is wrong-path, so its decode is ignored.
                ST_FLUSH: begin
                    if (!bus.stall) begin
                        pc_r  <= pc_r + 16'd1;
                        cnt_r <= cnt_r - 3'd1;
                        if (cnt_r == 3'd1) begin
                            flush_r <= 1'b0;
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    halted_r <= 1'b1;
                    flush_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_RUN;
                    cnt_r    <= 3'd0;
                    flush_r  <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc     = pc_r;
    assign bus.flush  = flush_r;
    assign bus.halted = halted_r;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a cycle-level reference model.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          NFLUSH = 2;

    logic clk;
    logic rst_n;
    pc_redirect_ctrl_if bus ();

    pc_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(NFLUSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: remaining squashed advances, frozen flag, expected pc.
    logic [15:0] m_pc;
    int          m_left;
    bit          m_halt;

    function automatic logic [15:0] m_target(input logic [15:0] instr, input logic [15:0] inc,
                                             input logic [15:0] rs);
        int off;
        case (instr[15:12])
            OP_B: begin
                off = int'(instr[7:0]);
                if (off >= 128) off = off - 256;
            end
            OP_JAL: begin
                off = int'(instr[11:0]);
                if (off >= 2048) off = off - 4096;
            end
            default: return rs;
        endcase
        return 16'((int'(inc) + off + 65536) % 65536);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc   <= RST_PC;
            m_left <= 0;
            m_halt <= 1'b0;
        end else if (m_halt) begin
            m_pc <= m_pc;
        end else if (m_left > 0) begin
            if (!bus.stall) begin
                m_pc   <= 16'((int'(m_pc) + 1) % 65536);
                m_left <= m_left - 1;
            end
        end else if (bus.ex_valid && ((bus.ex_instr[15:12] == OP_B && bus.br_taken) ||
                     bus.ex_instr[15:12] == OP_JAL || bus.ex_instr[15:12] == OP_JR)) begin
            m_pc   <= m_target(bus.ex_instr, bus.ex_pc_inc, bus.rs_data);
            m_left <= NFLUSH;
        end else if (bus.ex_valid && bus.ex_instr[15:12] == OP_HLT && !bus.stall) begin
            m_halt <= 1'b1;
        end else if (!bus.stall) begin
            m_pc <= 16'((int'(m_pc) + 1) % 65536);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",     bus.pc,              m_pc);
            chk("flush",  {15'd0, bus.flush},  {15'd0, m_left > 0});
            chk("halted", {15'd0, bus.halted}, {15'd0, m_halt});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] inc,
                         input logic br, input logic [15:0] rs, input logic st);
        bus.ex_valid  = v;
        bus.ex_instr  = instr;
        bus.ex_pc_inc = inc;
        bus.br_taken  = br;
        bus.rs_data   = rs;
        bus.stall     = st;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    // Hand-computed expectations pin both the DUT and the model.
    task automatic lit(input string name, input logic [15:0] pc_e, input logic fl_e, input logic h_e);
        chk({name, "_pc"},    bus.pc, pc_e);
        chk({name, "_flush"}, {15'd0, bus.flush}, {15'd0, fl_e});
        chk({name, "_halt"},  {15'd0, bus.halted}, {15'd0, h_e});
        chk({name, "_model"}, m_pc, pc_e);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        chk_en = 1'b1;
        lit("reset", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) step();
        lit("inc4", 16'h0004, 1'b0, 1'b0);

        // Taken branch, offset -4 from 0x0010
        drive(1'b1, {OP_B, 4'h0, 8'hFC}, 16'h0010, 1'b1, 16'h0000, 1'b0);
        step(); lit("b_tgt", 16'h000C, 1'b1, 1'b0);
        idle();
        step(); lit("b_fl2", 16'h000D, 1'b1, 1'b0);
        step(); lit("b_end", 16'h000E, 1'b0, 1'b0);

        // Not-taken branch is a plain increment
        drive(1'b1, {OP_B, 4'h0, 8'hFC}, 16'h0010, 1'b0, 16'h0000, 1'b0);
        step(); lit("b_nt", 16'h000F, 1'b0, 1'b0);

        // JAL with wrap
        drive(1'b1, {OP_JAL, 12'h7FF}, 16'hF900, 1'b0, 16'h0000, 1'b0);
        step(); lit("jal", 16'h00FF, 1'b1, 1'b0);
        idle();
        step(); step(); lit("jal_end", 16'h0101, 1'b0, 1'b0);

        // JR under stall, then a stall inside FLUSH
        drive(1'b1, {OP_JR, 12'h000}, 16'h0000, 1'b0, 16'h1234, 1'b1);
        step(); lit("jr", 16'h1234, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        step(); lit("jr_stall", 16'h1234, 1'b1, 1'b0);
        idle();
        step(); lit("jr_fl2", 16'h1235, 1'b1, 1'b0);
        step(); lit("jr_end", 16'h1236, 1'b0, 1'b0);

        // Invalid JR is not a redirect
        drive(1'b0, {OP_JR, 12'h000}, 16'h0000, 1'b0, 16'h5555, 1'b0);
        step(); lit("jr_inv", 16'h1237, 1'b0, 1'b0);

        // Redirect, then taken B and HLT inside FLUSH are ignored
        drive(1'b1, {OP_JAL, 12'h000}, 16'h2000, 1'b0, 16'h0000, 1'b0);
        step();
        drive(1'b1, {OP_B, 4'h0, 8'h10}, 16'h3000, 1'b1, 16'h0000, 1'b0);
        step(); lit("fl_b", 16'h2001, 1'b1, 1'b0);
        drive(1'b1, {OP_HLT, 12'h000}, 16'h0000, 1'b0, 16'h0000, 1'b0);
        step(); lit("fl_hlt", 16'h2002, 1'b0, 1'b0);

        // HLT in RUN, then redirect stimulus is ignored
        step(); lit("halt", 16'h2002, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {OP_JAL, 12'h123}, 16'h4000, 1'b0, 16'h0000, 1'(i % 2));
            step();
        end
        lit("halt_frz", 16'h2002, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(); lit("halt_rst", RST_PC, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle();

        // Reset during the second flush cycle
        drive(1'b1, {OP_JAL, 12'h000}, 16'h0050, 1'b0, 16'h0000, 1'b0);
        step();
        idle();
        step(); lit("fl_mid", 16'h0051, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(); lit("fl_rst", RST_PC, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(); lit("post_rst", 16'h0001, 1'b0, 1'b0);

        // PC wrap from FFFF in RUN
        drive(1'b1, {OP_JR, 12'h000}, 16'h0000, 1'b0, 16'hFFFD, 1'b0);
        step();
        idle();
        step(); step(); lit("pre_wrap", 16'hFFFF, 1'b0, 1'b0);
        step(); lit("wrap", 16'h0000, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
